mor1kx_store_buffer_drain: RTL and testbench
============================================

# mor1kx_store_buffer_drain

Consumer side of the store buffer FIFO. It pops queued stores (address, data, byte select, pc, atomic flag) and issues each one as a single data-bus write, strictly in order, one at a time. It reports per-store atomic (swa) results and bus errors with the faulting pc and address. It sits between the store buffer and the data-bus arbiter in the LSU.

## Interface
Parameters:
- OPTION_OPERAND_WIDTH, 32, width of pc, address and data; byte-select width is OPTION_OPERAND_WIDTH/8

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- sb_empty_i  in  1  store buffer empty
- sb_read_o  out  1  pop request; the sb_* data is valid the cycle after the pop
- sb_pc_i / sb_adr_i / sb_dat_i  in  OPTION_OPERAND_WIDTH  popped entry fields
- sb_bsel_i  in  OPTION_OPERAND_WIDTH/8  popped byte select
- sb_atomic_i  in  1  popped entry is a store-conditional
- dbus_req_o  out  1  write request, held until ack or err
- dbus_adr_o / dbus_dat_o  out  OPTION_OPERAND_WIDTH  write address and data
- dbus_bsel_o  out  OPTION_OPERAND_WIDTH/8  byte select
- dbus_atomic_o  out  1  current write is atomic
- dbus_ack_i / dbus_err_i  in  1  completion and error, single-cycle, mutually exclusive
- dbus_atomic_flag_i  in  1  swa success, valid with dbus_ack_i
- atomic_done_o  out  1  one-cycle pulse when an atomic write is acked
- atomic_flag_o  out  1  captured swa result, held until the next atomic ack
- store_err_o  out  1  sticky bus error
- store_err_pc_o / store_err_adr_o  out  OPTION_OPERAND_WIDTH  pc and address of the failed store
- err_clear_i  in  1  clears the error and resumes draining
- idle_o  out  1  state IDLE and sb_empty_i

## Operation
- States: IDLE, FETCH, WRITE, ERROR.
- IDLE: if !sb_empty_i, assert sb_read_o (combinational, one cycle) and go to FETCH.
- FETCH: register all sb_* fields into the entry registers, set dbus_req_o, and go to WRITE.
- WRITE: hold dbus_req_o and the entry registers stable.
  - On dbus_ack_i: clear dbus_req_o. If the entry is atomic, pulse atomic_done_o and load atomic_flag_o from dbus_atomic_flag_i. Go to IDLE, or to FETCH when prefetch applies (see Configuration).
  - On dbus_err_i: clear dbus_req_o, set store_err_o, capture the pc and address into store_err_pc_o and store_err_adr_o, and go to ERROR.
- ERROR: no pops and no requests.
  - err_clear_i clears store_err_o and returns to IDLE.
  - store_err_pc_o and store_err_adr_o keep their values until the next error.
- err_clear_i in any other state: no effect.
- sb_read_o is never asserted while sb_empty_i=1, nor in FETCH or ERROR.
- Ordering: at most one write is outstanding. Entries are issued exactly in FIFO order.
- Asynchronous reset at any point, including mid-WRITE: return to IDLE immediately and drop dbus_req_o. The in-flight entry is discarded; the store buffer is reset by the same rst.
- Reset values: sb_read_o=0, dbus_req_o=0, dbus_adr_o/dat_o/bsel_o=0, dbus_atomic_o=0, atomic_done_o=0, atomic_flag_o=0, store_err_o=0, store_err_pc_o/adr_o=0, idle_o=sb_empty_i.

## Timing
- Pop to request: sb_read_o in cycle N, capture in N+1, dbus_req_o high from N+2.
- Ack to next request:
  - with prefetch: 2 cycles
  - without prefetch: 3 cycles
- Steady-state throughput with ack in the first WRITE cycle:
  - with prefetch: 1 store per 2 cycles
  - without prefetch: 1 store per 3 cycles
- atomic_done_o and atomic_flag_o update in the cycle after the ack. store_err_o is set in the cycle after the error.
- A store arriving while the buffer is empty in IDLE: pop in the cycle sb_empty_i falls.

## Configuration
- MOR1KX_STORE_BUFFER_DRAIN_PREFETCH_EN defined: in the WRITE cycle with dbus_ack_i and !sb_empty_i, assert sb_read_o in that same cycle and go directly to FETCH.
- Undefined: ack always goes to IDLE, and the pop happens from IDLE.
- Error handling never prefetches.

## Structure
- Shared package: state encoding constants (IDLE/FETCH/WRITE/ERROR), entry-field packing order {adr, dat, bsel, pc, atomic} matching the store buffer.
- Sub-module: none; single FSM plus entry and error registers.

## Test plan
- Single store adr=0x100, dat=0xDEADBEEF, bsel=0xF, ack on first request cycle -> one pop, dbus_req_o high exactly 1 cycle with those values, idle_o=1 afterwards.
- Four back-to-back stores, ack with 0-wait -> issued in order. Request-to-request spacing is 2 cycles with MOR1KX_STORE_BUFFER_DRAIN_PREFETCH_EN and 3 cycles without.
- Atomic store with ack, dbus_atomic_flag_i=1, then atomic with flag=0 -> atomic_done_o pulses twice; atomic_flag_o reads 1 then 0.
- Second of three stores gets dbus_err_i at pc=0x2004, adr=0x3000 -> store_err_o=1 with those values captured, no further pops. err_clear_i -> third store issues.
- Assert rst during WRITE with a 5-cycle ack delay -> dbus_req_o=0 immediately, state IDLE, all outputs at reset values.
- Request held 7 cycles before ack -> dbus_adr_o, dbus_dat_o and dbus_bsel_o stable throughout, no sb_read_o during the wait.

Source files
------------

// File: rtl/mor1kx_store_buffer_drain_pkg.sv
// ---------------------------------------------------------------------------
// mor1kx_store_buffer_drain_pkg
//
// Shared definitions for the store buffer drain logic:
//   - drain_state_t : FSM state encoding (IDLE / FETCH / WRITE / ERROR)
//   - entry layout  : the store buffer packs an entry as
//                     {adr, dat, bsel, pc, atomic} (MSB -> LSB).
//                     The helper functions give the width of a packed entry
//                     and the LSB of each field for a given operand width.
// ---------------------------------------------------------------------------
package mor1kx_store_buffer_drain_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WRITE = 2'd2,
    ERROR = 2'd3
  } drain_state_t;

  // Total width of one packed entry: adr + dat + pc + bsel + atomic
  function automatic int entry_width(input int ow);
    return 3 * ow + ow / 8 + 1;
  endfunction

  // The atomic flag sits in bit 0, everything else is stacked above it
  function automatic int entry_pc_lsb(input int ow);
    return (ow > 0) ? 1 : 1;
  endfunction

  function automatic int entry_bsel_lsb(input int ow);
    return 1 + ow;
  endfunction

  function automatic int entry_dat_lsb(input int ow);
    return 1 + ow + ow / 8;
  endfunction

  function automatic int entry_adr_lsb(input int ow);
    return 1 + 2 * ow + ow / 8;
  endfunction

endpackage

// File: rtl/mor1kx_store_buffer_drain.sv
// ---------------------------------------------------------------------------
// mor1kx_store_buffer_drain
//
// Consumer side of the LSU store buffer. Pops queued stores one at a time
// and issues each as a single data-bus write, strictly in FIFO order with at
// most one write outstanding. Reports swa (store-conditional) results and
// latches the pc/address of a store that took a bus error.
//
// Configuration macro:
//   MOR1KX_STORE_BUFFER_DRAIN_PREFETCH_EN
//     defined   : on the ack cycle, if the buffer is not empty, the next
//                 entry is popped immediately and the FSM goes straight to
//                 FETCH (ack-to-next-request = 2 cycles).
//     undefined : every ack returns to IDLE, which then pops
//                 (ack-to-next-request = 3 cycles).
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   sb_empty_i           store buffer empty
//   sb_read_o            pop request (combinational); sb_* valid next cycle
//   sb_pc_i/adr_i/dat_i  popped entry fields
//   sb_bsel_i            popped byte select
//   sb_atomic_i          popped entry is a store-conditional
//   dbus_req_o           write request, held until ack or err
//   dbus_adr_o/dat_o     write address / data
//   dbus_bsel_o          write byte select
//   dbus_atomic_o        current write is atomic
//   dbus_ack_i/err_i     single-cycle completion / error
//   dbus_atomic_flag_i   swa success, valid with dbus_ack_i
//   atomic_done_o        one-cycle pulse after an atomic write is acked
//   atomic_flag_o        last swa result
//   store_err_o          sticky bus error
//   store_err_pc_o/adr_o pc / address of the failed store
//   err_clear_i          clears the error and resumes draining
//   idle_o               FSM idle and store buffer empty
// ---------------------------------------------------------------------------
module mor1kx_store_buffer_drain
  import mor1kx_store_buffer_drain_pkg::*;
#(
  parameter int OPTION_OPERAND_WIDTH = 32
) (
  input  logic                              clk,
  input  logic                              rst,

  input  logic                              sb_empty_i,
  output logic                              sb_read_o,
  input  logic [OPTION_OPERAND_WIDTH-1:0]   sb_pc_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0]   sb_adr_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0]   sb_dat_i,
  input  logic [OPTION_OPERAND_WIDTH/8-1:0] sb_bsel_i,
  input  logic                              sb_atomic_i,

  output logic                              dbus_req_o,
  output logic [OPTION_OPERAND_WIDTH-1:0]   dbus_adr_o,
  output logic [OPTION_OPERAND_WIDTH-1:0]   dbus_dat_o,
  output logic [OPTION_OPERAND_WIDTH/8-1:0] dbus_bsel_o,
  output logic                              dbus_atomic_o,
  input  logic                              dbus_ack_i,
  input  logic                              dbus_err_i,
  input  logic                              dbus_atomic_flag_i,

  output logic                              atomic_done_o,
  output logic                              atomic_flag_o,

  output logic                              store_err_o,
  output logic [OPTION_OPERAND_WIDTH-1:0]   store_err_pc_o,
  output logic [OPTION_OPERAND_WIDTH-1:0]   store_err_adr_o,
  input  logic                              err_clear_i,

  output logic                              idle_o
);

  localparam int OW       = OPTION_OPERAND_WIDTH;
  localparam int BW       = OPTION_OPERAND_WIDTH / 8;
  localparam int EW       = entry_width(OW);
  localparam int PC_LSB   = entry_pc_lsb(OW);
  localparam int BSEL_LSB = entry_bsel_lsb(OW);
  localparam int DAT_LSB  = entry_dat_lsb(OW);
  localparam int ADR_LSB  = entry_adr_lsb(OW);

  drain_state_t  state;
  logic [EW-1:0] sb_entry;
  logic [EW-1:0] entry_q;
  logic          prefetch;

  // Incoming entry packed in the same order the store buffer uses, so the
  // entry register is a straight copy of one FIFO word.
  assign sb_entry = {sb_adr_i, sb_dat_i, sb_bsel_i, sb_pc_i, sb_atomic_i};

  // The bus sees the entry register directly; it only changes in FETCH,
  // which guarantees the write fields are stable while dbus_req_o is high.
  assign dbus_adr_o    = entry_q[ADR_LSB  +: OW];
  assign dbus_dat_o    = entry_q[DAT_LSB  +: OW];
  assign dbus_bsel_o   = entry_q[BSEL_LSB +: BW];
  assign dbus_atomic_o = entry_q[0];

  // Back-to-back pop on the ack cycle. An error never prefetches because
  // only dbus_ack_i qualifies it.
`ifdef MOR1KX_STORE_BUFFER_DRAIN_PREFETCH_EN
  assign prefetch = (state == WRITE) && dbus_ack_i && !sb_empty_i;
`else
  assign prefetch = 1'b0;
`endif

  // Pop is combinational so a store arriving into an idle, empty buffer is
  // popped in the same cycle sb_empty_i falls. Masked during reset so the
  // store buffer never sees a pop while both blocks are being reset.
  assign sb_read_o = !rst && !sb_empty_i && ((state == IDLE) || prefetch);

  assign idle_o = (state == IDLE) && sb_empty_i;

  // Drain FSM plus entry, swa result and error registers.
  // atomic_done_o defaults low every cycle so it only pulses for one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      entry_q         <= '0;
      dbus_req_o      <= 1'b0;
      atomic_done_o   <= 1'b0;
      atomic_flag_o   <= 1'b0;
      store_err_o     <= 1'b0;
      store_err_pc_o  <= '0;
      store_err_adr_o <= '0;
    end else begin
      atomic_done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (!sb_empty_i)
            state <= FETCH;
        end

        FETCH: begin
          entry_q    <= sb_entry;
          dbus_req_o <= 1'b1;
          state      <= WRITE;
        end

        WRITE: begin
          if (dbus_ack_i) begin
            dbus_req_o <= 1'b0;
            if (entry_q[0]) begin
              atomic_done_o <= 1'b1;
              atomic_flag_o <= dbus_atomic_flag_i;
            end
            state <= prefetch ? FETCH : IDLE;
          end else if (dbus_err_i) begin
            dbus_req_o      <= 1'b0;
            store_err_o     <= 1'b1;
            store_err_pc_o  <= entry_q[PC_LSB +: OW];
            store_err_adr_o <= entry_q[ADR_LSB +: OW];
            state           <= ERROR;
          end
        end

        ERROR: begin
          if (err_clear_i) begin
            store_err_o <= 1'b0;
            state       <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mor1kx_store_buffer_drain.sv
// ---------------------------------------------------------------------------
// tb_mor1kx_store_buffer_drain
//
// Self-checking bench for mor1kx_store_buffer_drain. A queue models the store
// buffer, a second queue holds the expected bus writes in issue order, and a
// small bus responder acks (or errors) each request after a programmable
// wait. Honours MOR1KX_STORE_BUFFER_DRAIN_PREFETCH_EN for the spacing checks.
// ---------------------------------------------------------------------------
module tb_mor1kx_store_buffer_drain;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  bsel;
    logic        atomic;
    logic        swa_ok;
    logic        bus_err;
  } tb_store_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sb_empty_i = 1'b1;
  logic        sb_read_o;
  logic [31:0] sb_pc_i = '0;
  logic [31:0] sb_adr_i = '0;
  logic [31:0] sb_dat_i = '0;
  logic [3:0]  sb_bsel_i = '0;
  logic        sb_atomic_i = 1'b0;
  logic        dbus_req_o;
  logic [31:0] dbus_adr_o;
  logic [31:0] dbus_dat_o;
  logic [3:0]  dbus_bsel_o;
  logic        dbus_atomic_o;
  logic        dbus_ack_i = 1'b0;
  logic        dbus_err_i = 1'b0;
  logic        dbus_atomic_flag_i = 1'b0;
  logic        atomic_done_o;
  logic        atomic_flag_o;
  logic        store_err_o;
  logic [31:0] store_err_pc_o;
  logic [31:0] store_err_adr_o;
  logic        err_clear_i = 1'b0;
  logic        idle_o;

  mor1kx_store_buffer_drain #(.OPTION_OPERAND_WIDTH(32)) dut (
    .clk                (clk),
    .rst                (rst),
    .sb_empty_i         (sb_empty_i),
    .sb_read_o          (sb_read_o),
    .sb_pc_i            (sb_pc_i),
    .sb_adr_i           (sb_adr_i),
    .sb_dat_i           (sb_dat_i),
    .sb_bsel_i          (sb_bsel_i),
    .sb_atomic_i        (sb_atomic_i),
    .dbus_req_o         (dbus_req_o),
    .dbus_adr_o         (dbus_adr_o),
    .dbus_dat_o         (dbus_dat_o),
    .dbus_bsel_o        (dbus_bsel_o),
    .dbus_atomic_o      (dbus_atomic_o),
    .dbus_ack_i         (dbus_ack_i),
    .dbus_err_i         (dbus_err_i),
    .dbus_atomic_flag_i (dbus_atomic_flag_i),
    .atomic_done_o      (atomic_done_o),
    .atomic_flag_o      (atomic_flag_o),
    .store_err_o        (store_err_o),
    .store_err_pc_o     (store_err_pc_o),
    .store_err_adr_o    (store_err_adr_o),
    .err_clear_i        (err_clear_i),
    .idle_o             (idle_o)
  );

  // Free-running clock: posedges at 5, 15, ...; inputs change on negedges
  always #5 clk = ~clk;

  localparam int EXP_SPACING =
`ifdef MOR1KX_STORE_BUFFER_DRAIN_PREFETCH_EN
    2;
`else
    3;
`endif

  tb_store_t   sb_q[$];
  tb_store_t   exp_q[$];
  int          rise_q[$];
  logic        done_flags[$];

  int          n_checks = 0;
  int          n_pass = 0;
  int          cycle = 0;
  int          ack_delay = 0;
  int          wait_cnt = 0;
  bit          pop_pending = 0;
  bit          clear_req = 0;
  bit          req_prev = 0;
  logic [67:0] held = '0;
  int          pops = 0;
  int          empty_pops = 0;
  int          wait_pops = 0;
  int          unstable = 0;
  int          req_cycles = 0;
  int          req_len = 0;
  int          last_req_len = 0;
  int          last_pop_cycle = 0;
  int          last_rise = 0;
  int          completions = 0;
  int          errors = 0;
  int          done_cnt = 0;
  int          atomic_ack_cycle = 0;
  int          done_lag = 0;

  // Count one comparison and report it if the observed value is wrong
  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    n_checks++;
    if (observed === expected)
      n_pass++;
    else
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
  endtask

  // Queue one store into the modelled store buffer and the expected writes
  task automatic applyStimulus(input logic [31:0] pc, input logic [31:0] adr,
                               input logic [31:0] dat, input logic [3:0] bsel,
                               input logic atomic, input logic swa_ok,
                               input logic bus_err);
    tb_store_t s;
    s.pc = pc; s.adr = adr; s.dat = dat; s.bsel = bsel;
    s.atomic = atomic; s.swa_ok = swa_ok; s.bus_err = bus_err;
    sb_q.push_back(s);
    exp_q.push_back(s);
  endtask

  // One clock cycle: drive inputs on the negedge (store buffer data for the
  // pop taken at the last posedge, bus response), then sample the outputs
  // 1 time unit later and update the scoreboard and event counters.
  task automatic stepCycle();
    tb_store_t cur;
    tb_store_t exp;
    @(negedge clk);
    cycle++;
    if (pop_pending) begin
      if (sb_q.size() > 0) begin
        cur = sb_q.pop_front();
        sb_pc_i = cur.pc; sb_adr_i = cur.adr; sb_dat_i = cur.dat;
        sb_bsel_i = cur.bsel; sb_atomic_i = cur.atomic;
      end
      pop_pending = 0;
    end
    sb_empty_i  = (sb_q.size() == 0);
    err_clear_i = clear_req;
    dbus_ack_i = 1'b0; dbus_err_i = 1'b0; dbus_atomic_flag_i = 1'b0;
    if (dbus_req_o && !rst) begin
      if (wait_cnt >= ack_delay && exp_q.size() > 0) begin
        if (exp_q[0].bus_err) dbus_err_i = 1'b1;
        else begin
          dbus_ack_i = 1'b1;
          dbus_atomic_flag_i = exp_q[0].swa_ok;
        end
      end
      wait_cnt++;
    end else begin
      wait_cnt = 0;
    end
    #1;
    if (sb_read_o) begin
      pops++;
      pop_pending = 1;
      last_pop_cycle = cycle;
      if (sb_empty_i) empty_pops++;
      if (dbus_req_o && !dbus_ack_i) wait_pops++;
    end
    if (dbus_req_o) begin
      if (!req_prev) begin
        rise_q.push_back(cycle);
        last_rise = cycle;
        req_len = 0;
      end else if ({dbus_adr_o, dbus_dat_o, dbus_bsel_o} != held) begin
        unstable++;
      end
      held = {dbus_adr_o, dbus_dat_o, dbus_bsel_o};
      req_len++;
      req_cycles++;
      if ((dbus_ack_i || dbus_err_i) && exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        checkOutput(dbus_err_i ? "err_write" : "ack_write",
                    {59'd0, dbus_adr_o, dbus_dat_o, dbus_bsel_o, dbus_atomic_o},
                    {59'd0, exp.adr, exp.dat, exp.bsel, exp.atomic});
        last_req_len = req_len;
        if (dbus_ack_i) begin
          completions++;
          if (dbus_atomic_o) atomic_ack_cycle = cycle;
        end else begin
          errors++;
        end
      end
    end
    if (atomic_done_o) begin
      done_cnt++;
      done_flags.push_back(atomic_flag_o);
      done_lag = cycle - atomic_ack_cycle;
    end
    req_prev = dbus_req_o;
  endtask

  task automatic stepCycles(input int n);
    for (int i = 0; i < n; i++) stepCycle();
  endtask

  // Run until the given completion/error totals are reached or the budget
  // runs out; the final comparison fails on an expired budget.
  task automatic waitEvents(input int want_done, input int want_err,
                            input int budget, input string tag);
    int b;
    b = 0;
    while ((completions < want_done || errors < want_err) && b < budget) begin
      stepCycle();
      b++;
    end
    checkOutput(tag, {64'd0, 32'(completions), 32'(errors)},
                {64'd0, 32'(want_done), 32'(want_err)});
  endtask

  initial begin : main
    int p0;
    int r0;
    int b;

    // Reset state
    stepCycles(2);
    checkOutput("reset_req", {127'd0, dbus_req_o}, 128'd0);
    checkOutput("reset_read", {127'd0, sb_read_o}, 128'd0);
    checkOutput("reset_err", {127'd0, store_err_o}, 128'd0);
    checkOutput("reset_idle", {127'd0, idle_o}, 128'd1);
    rst = 1'b0;
    stepCycles(2);

    // Single store, ack on the first request cycle
    ack_delay = 0;
    p0 = pops; r0 = req_cycles;
    applyStimulus(32'h1000, 32'h100, 32'hDEADBEEF, 4'hF, 1'b0, 1'b0, 1'b0);
    waitEvents(1, 0, 50, "single_done");
    stepCycles(3);
    checkOutput("single_pops", 128'(pops - p0), 128'd1);
    checkOutput("single_req_len", 128'(req_cycles - r0), 128'd1);
    checkOutput("pop_to_req", 128'(last_rise - last_pop_cycle), 128'd2);
    checkOutput("single_idle", {127'd0, idle_o}, 128'd1);

    // Four back-to-back stores, zero-wait acks
    rise_q.delete();
    for (int i = 0; i < 4; i++)
      applyStimulus(32'h1100 + 32'(4 * i), 32'h200 + 32'(4 * i),
                    32'hA5A50000 + 32'(i), 4'(1 << i), 1'b0, 1'b0, 1'b0);
    waitEvents(5, 0, 100, "burst_done");
    checkOutput("burst_rises", 128'(rise_q.size()), 128'd4);
    for (int i = 1; i < 4 && i < rise_q.size(); i++)
      checkOutput("burst_spacing", 128'(rise_q[i] - rise_q[i-1]), 128'(EXP_SPACING));
    stepCycles(2);

    // Two atomic stores: swa success then failure
    done_cnt = 0;
    done_flags.delete();
    applyStimulus(32'h1200, 32'h400, 32'h11111111, 4'hF, 1'b1, 1'b1, 1'b0);
    applyStimulus(32'h1204, 32'h404, 32'h22222222, 4'hF, 1'b1, 1'b0, 1'b0);
    waitEvents(7, 0, 60, "atomic_done");
    stepCycles(3);
    checkOutput("atomic_pulses", 128'(done_cnt), 128'd2);
    if (done_flags.size() == 2) begin
      checkOutput("atomic_flag_first", {127'd0, done_flags[0]}, 128'd1);
      checkOutput("atomic_flag_second", {127'd0, done_flags[1]}, 128'd0);
    end
    checkOutput("atomic_done_lag", 128'(done_lag), 128'd1);
    checkOutput("atomic_flag_held", {127'd0, atomic_flag_o}, 128'd0);

    // Bus error on the second of three stores
    applyStimulus(32'h2000, 32'h2FFC, 32'h33333333, 4'hF, 1'b0, 1'b0, 1'b0);
    applyStimulus(32'h2004, 32'h3000, 32'h44444444, 4'h3, 1'b0, 1'b0, 1'b1);
    applyStimulus(32'h2008, 32'h3004, 32'h55555555, 4'hC, 1'b0, 1'b0, 1'b0);
    waitEvents(8, 1, 60, "err_seen");
    stepCycles(2);
    checkOutput("err_flag", {127'd0, store_err_o}, 128'd1);
    checkOutput("err_pc", {96'd0, store_err_pc_o}, {96'd0, 32'h2004});
    checkOutput("err_adr", {96'd0, store_err_adr_o}, {96'd0, 32'h3000});
    p0 = pops; r0 = req_cycles;
    stepCycles(8);
    checkOutput("err_no_pops", 128'(pops - p0), 128'd0);
    checkOutput("err_no_req", 128'(req_cycles - r0), 128'd0);
    checkOutput("err_sb_left", 128'(sb_q.size()), 128'd1);
    clear_req = 1'b1;
    stepCycle();
    clear_req = 1'b0;
    waitEvents(9, 1, 50, "err_resume");
    stepCycles(2);
    checkOutput("err_cleared", {127'd0, store_err_o}, 128'd0);
    checkOutput("err_pc_kept", {96'd0, store_err_pc_o}, {96'd0, 32'h2004});

    // Request held 7 cycles before ack; the second entry must wait its turn
    ack_delay = 6;
    wait_pops = 0; unstable = 0;
    applyStimulus(32'h2100, 32'h5000, 32'hCAFEF00D, 4'h6, 1'b0, 1'b0, 1'b0);
    applyStimulus(32'h2104, 32'h5004, 32'h0BADC0DE, 4'h9, 1'b1, 1'b1, 1'b0);
    waitEvents(10, 1, 60, "hold_first");
    checkOutput("hold_len", 128'(last_req_len), 128'd7);
    waitEvents(11, 1, 60, "hold_second");
    stepCycles(2);
    checkOutput("hold_stable", 128'(unstable), 128'd0);
    checkOutput("hold_no_pop", 128'(wait_pops), 128'd0);
    checkOutput("hold_flag_set", {127'd0, atomic_flag_o}, 128'd1);

    // Reset in the middle of a slow write
    ack_delay = 5;
    applyStimulus(32'h2200, 32'h6000, 32'h12345678, 4'hF, 1'b1, 1'b0, 1'b0);
    b = 0;
    while (!dbus_req_o && b < 20) begin
      stepCycle();
      b++;
    end
    checkOutput("rst_req_before", {127'd0, dbus_req_o}, 128'd1);
    stepCycles(2);
    rst = 1'b1;
    #1;
    checkOutput("rst_req_drop", {127'd0, dbus_req_o}, 128'd0);
    checkOutput("rst_fields", {59'd0, dbus_adr_o, dbus_dat_o, dbus_bsel_o, dbus_atomic_o}, 128'd0);
    checkOutput("rst_flags", {124'd0, atomic_done_o, atomic_flag_o, store_err_o, sb_read_o}, 128'd0);
    checkOutput("rst_err_regs", {64'd0, store_err_pc_o, store_err_adr_o}, 128'd0);
    checkOutput("rst_idle", {127'd0, idle_o}, {127'd0, sb_empty_i});
    sb_q.delete();
    exp_q.delete();
    pop_pending = 0;
    stepCycles(2);
    rst = 1'b0;
    stepCycles(2);
    checkOutput("rst_idle_after", {127'd0, idle_o}, 128'd1);

    // Draining resumes normally after the reset
    ack_delay = 0;
    applyStimulus(32'h2300, 32'h7000, 32'h87654321, 4'h1, 1'b0, 1'b0, 1'b0);
    waitEvents(12, 1, 50, "post_rst_done");
    checkOutput("empty_pops", 128'(empty_pops), 128'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
